// File: rtl/aes_mixcol_engine.sv
// aes_mixcol_engine: handshaked AES MixColumns / InvMixColumns engine.
// Latches one 128-bit state at accept, transforms COLS_PER_CYC columns per
// clock in place, then holds the result until the consumer takes it.
// Optional feature macro: AES_MC_BYPASS_EN adds i_bypass, which passes the
// state through unchanged (final AES round) with the same latency.
//
// state | meaning
// IDLE  | no transaction, o_ready high
// BUSY  | transforming COLS_PER_CYC columns per clock, cnt selects the group
// DONE  | result presented on o_data, held until i_ready

module aes_mixcol_engine #(
  parameter int COLS_PER_CYC = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_inv,
`ifdef AES_MC_BYPASS_EN
  input  logic         i_bypass,
`endif
  input  logic [127:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data,
  output logic         o_busy
);

  generate
    if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2 && COLS_PER_CYC != 4) begin : gen_bad_cols
      $error("aes_mixcol_engine: COLS_PER_CYC must be 1, 2 or 4");
    end
  endgenerate

  localparam int         N_CYC    = (COLS_PER_CYC > 0) ? (4 / COLS_PER_CYC) : 1;
  localparam logic [1:0] CNT_LAST = 2'(N_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic         inv_q, inv_d;
  logic         byp;
  logic         accept;
  logic [1:0]   col_idx;
  logic [31:0]  col_in;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through either matrix; multiples built from a shared xtime chain.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    logic [1:0]  r0, r1, r2, r3;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      r0     = 2'(r);
      a[r0]  = col[31-8*r -: 8];
      x2[r0] = xtime(a[r0]);
      x4[r0] = xtime(x2[r0]);
      x8[r0] = xtime(x4[r0]);
    end
    for (int r = 0; r < 4; r++) begin
      r0 = 2'(r);
      r1 = r0 + 2'd1;
      r2 = r0 + 2'd2;
      r3 = r0 + 2'd3;
      if (!inv)
        res[31-8*r -: 8] = x2[r0] ^ (x2[r1] ^ a[r1]) ^ a[r2] ^ a[r3];
      else
        res[31-8*r -: 8] = (x8[r0] ^ x4[r0] ^ x2[r0]) ^ (x8[r1] ^ x2[r1] ^ a[r1]) ^
                           (x8[r2] ^ x4[r2] ^ a[r2]) ^ (x8[r3] ^ a[r3]);
    end
    return res;
  endfunction

`ifdef AES_MC_BYPASS_EN
  logic bypass_q, bypass_d;

  // Bypass flag captured at accept, cleared by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) bypass_q <= 1'b0;
    else          bypass_q <= bypass_d;
  end

  assign byp = bypass_q;
`else
  assign byp = 1'b0;
`endif

  // State, column counter, working state and mode registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      data_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
    end
  end

  // Next-state, in-place column update and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    inv_d    = inv_q;
`ifdef AES_MC_BYPASS_EN
    bypass_d = bypass_q;
`endif
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    accept   = 1'b0;
    col_idx  = 2'd0;
    col_in   = '0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        accept  = i_valid;
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYC; k++) begin
          col_idx = 2'(int'(cnt_q) * COLS_PER_CYC + k);
          col_in  = data_q[127-32*int'(col_idx) -: 32];
          data_d[127-32*int'(col_idx) -: 32] = byp ? col_in : mix_col(col_in, inv_q);
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          o_ready = 1'b1;
          if (i_valid) accept = 1'b1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new transaction always restarts from column 0 with fresh data and mode.
    if (accept) begin
      state_d  = BUSY;
      cnt_d    = 2'd0;
      data_d   = i_data;
      inv_d    = i_inv;
`ifdef AES_MC_BYPASS_EN
      bypass_d = i_bypass;
`endif
    end
  end

  assign o_data = data_q;
  assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Bench for aes_mixcol_engine: three instances (1, 2 and 4 columns per clock),
// each watched every cycle by a transaction-level MixColumns model.
module tb_aes_mixcol_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         t_valid   [3];
  logic         t_inv     [3];
  logic         t_byp     [3];
  logic         t_ready   [3];
  logic [127:0] t_data    [3];
  logic         t_o_ready [3];
  logic         t_o_valid [3];
  logic         t_o_busy  [3];
  logic [127:0] t_o_data  [3];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  // Generic GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Full-state matrix product with the circulant forward/inverse coefficients.
  function automatic logic [127:0] mc_model(input logic [127:0] s, input logic inv);
    logic [7:0]   kf [4];
    logic [7:0]   ki [4];
    logic [7:0]   acc;
    logic [127:0] o;
    kf = '{8'h02, 8'h03, 8'h01, 8'h01};
    ki = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(inv ? ki[(j - r + 4) % 4] : kf[(j - r + 4) % 4],
                           s[127 - 32*c - 8*j -: 8]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    return o;
  endfunction

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gen_dut
      localparam int CPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      localparam int NL  = 4 / CPC;

      aes_mixcol_engine #(.COLS_PER_CYC(CPC)) u_dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (t_valid[g]),
        .o_ready  (t_o_ready[g]),
        .i_inv    (t_inv[g]),
`ifdef AES_MC_BYPASS_EN
        .i_bypass (t_byp[g]),
`endif
        .i_data   (t_data[g]),
        .o_valid  (t_o_valid[g]),
        .i_ready  (t_ready[g]),
        .o_data   (t_o_data[g]),
        .o_busy   (t_o_busy[g])
      );

      logic         m_busy, m_done;
      int           m_left;
      logic [127:0] m_exp;

      // Transaction model: result computed at accept, valid NL edges later.
      always @(posedge clk or negedge rst_n) begin : model
        logic acc;
        if (!rst_n) begin
          m_busy <= 1'b0;
          m_done <= 1'b0;
          m_left <= 0;
          m_exp  <= '0;
        end else begin
          acc = t_valid[g] && ((!m_busy && !m_done) || (m_done && t_ready[g]));
          if (acc) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_left <= NL;
            m_exp  <= t_byp[g] ? t_data[g] : mc_model(t_data[g], t_inv[g]);
          end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
              m_busy <= 1'b0;
              m_done <= 1'b1;
            end
          end else if (m_done && t_ready[g]) begin
            m_done <= 1'b0;
          end
        end
      end

      // Compare every cycle on the falling edge.
      always @(negedge clk) begin
        check($sformatf("c%0d_valid", CPC), t_o_valid[g], m_done);
        check($sformatf("c%0d_ready", CPC), t_o_ready[g],
              (!m_busy && !m_done) || (m_done && t_ready[g]));
        check($sformatf("c%0d_busy", CPC), t_o_busy[g], m_busy || m_done);
        if (m_done) check($sformatf("c%0d_data", CPC), t_o_data[g], m_exp);
      end
    end
  endgenerate

  task automatic issue(input int i, input logic [127:0] d, input logic inv, input logic byp);
    int n;
    @(posedge clk); #1;
    t_valid[i] = 1'b1; t_data[i] = d; t_inv[i] = inv; t_byp[i] = byp;
    n = 0;
    while (!t_o_ready[i] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!t_o_ready[i]) check("issue_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    t_valid[i] = 1'b0;
    t_data[i]  = ~d;
    t_inv[i]   = ~inv;
  endtask

  task automatic wait_valid(input int i, input int n_exp, input string tag);
    int e;
    e = 0;
    while (!t_o_valid[i] && e < 12) begin
      check({tag, "_busy_ready"}, t_o_ready[i], 1'b0);
      @(posedge clk); #1; e++;
    end
    check({tag, "_valid"}, t_o_valid[i], 1'b1);
    check({tag, "_latency"}, 128'(e), 128'(n_exp));
  endtask

  localparam logic [127:0] V_A  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_AM = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_B  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V_BM = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V_C  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V_CM = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] V_D  = 128'h00112233_44556677_8899aabb_ccddeeff;

  initial begin
    logic [127:0] vecs [4];
    vecs = '{V_A, V_B, V_C, V_D};
    for (int i = 0; i < 3; i++) begin
      t_valid[i] = 1'b0; t_inv[i] = 1'b0; t_byp[i] = 1'b0;
      t_ready[i] = 1'b1; t_data[i] = '0;
    end
    rst_n = 1'b0;

    // Model pinned by known answers.
    check("model_fwd", mc_model(V_A, 1'b0), V_AM);
    check("model_inv", mc_model(V_AM, 1'b1), V_A);
    check("model_fips", mc_model(V_C, 1'b0), V_CM);

    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid%0d", i), t_o_valid[i], 1'b0);
      check($sformatf("rst_busy%0d", i),  t_o_busy[i],  1'b0);
      check($sformatf("rst_ready%0d", i), t_o_ready[i], 1'b1);
      check($sformatf("rst_data%0d", i),  t_o_data[i],  128'h0);
    end
    #20 rst_n = 1'b1;

    // 4 columns per clock, forward, one-edge latency.
    issue(2, V_A, 1'b0, 1'b0);
    wait_valid(2, 1, "c4_fwd");
    check("c4_fwd_data", t_o_data[2], V_AM);

    // 1 column per clock, inverse, four-edge latency with o_ready low.
    issue(0, V_AM, 1'b1, 1'b0);
    wait_valid(0, 4, "c1_inv");
    check("c1_inv_data", t_o_data[0], V_A);

    // 2 columns per clock, consumer stall then back-to-back accept.
    t_ready[1] = 1'b0;
    issue(1, V_B, 1'b0, 1'b0);
    wait_valid(1, 2, "c2_fwd");
    check("c2_fwd_data", t_o_data[1], V_BM);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("c2_hold_valid", t_o_valid[1], 1'b1);
      check("c2_hold_data", t_o_data[1], V_BM);
    end
    t_ready[1] = 1'b1; t_valid[1] = 1'b1; t_data[1] = V_AM; t_inv[1] = 1'b1; t_byp[1] = 1'b0;
    #1;
    check("c2_b2b_ready", t_o_ready[1], 1'b1);
    @(posedge clk); #1;
    t_valid[1] = 1'b0;
    check("c2_b2b_busy", t_o_busy[1], 1'b1);
    check("c2_b2b_valid_low", t_o_valid[1], 1'b0);
    wait_valid(1, 2, "c2_b2b");
    check("c2_b2b_data", t_o_data[1], V_A);

    // FIPS-197 round-1 column vector at 1 column per clock.
    issue(0, V_C, 1'b0, 1'b0);
    wait_valid(0, 4, "c1_fips");
    check("c1_fips_data", t_o_data[0], V_CM);

    // Reset while BUSY on the second column.
    issue(0, V_A, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rstmid_busy_before", t_o_busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", t_o_valid[0], 1'b0);
    check("rstmid_data", t_o_data[0], 128'h0);
    check("rstmid_ready", t_o_ready[0], 1'b1);
    check("rstmid_busy", t_o_busy[0], 1'b0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("rstmid_no_stale", t_o_valid[0], 1'b0);
    end

`ifdef AES_MC_BYPASS_EN
    for (int i = 0; i < 3; i++) begin
      issue(i, V_D, 1'b0, 1'b1);
      wait_valid(i, 4 >> i, $sformatf("byp%0d", i));
      check($sformatf("byp%0d_data", i), t_o_data[i], V_D);
      issue(i, V_D, 1'b0, 1'b0);
      wait_valid(i, 4 >> i, $sformatf("nobyp%0d", i));
      check($sformatf("nobyp%0d_data", i), t_o_data[i], mc_model(V_D, 1'b0));
    end
`endif

    // Table sweep, alternating modes; the per-cycle model checks the data.
    for (int i = 0; i < 3; i++)
      for (int v = 0; v < 4; v++) begin
        issue(i, vecs[v], (v % 2) == 1, 1'b0);
        wait_valid(i, 4 >> i, $sformatf("sweep%0d_%0d", i, v));
      end

    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_mixcol_engine.md
# aes_mixcol_engine

Parametrised, handshaked MixColumns/InvMixColumns engine for the AES round datapath, sitting between ShiftRows/InvShiftRows and AddRoundKey. It accepts one 128-bit state per transaction and holds it in an internal register. It then transforms `COLS_PER_CYC` 32-bit columns per clock, forward or inverse as selected per transaction. The result is held until the consumer accepts it. The engine trades area against latency in the same block and replaces the fixed combinational forward/inverse pair.

## Interface
Parameters:
- `COLS_PER_CYC`, default 1: columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- `i_clk`  in  1  single clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  input state valid.
- `o_ready`  out  1  engine can accept input this cycle.
- `i_inv`  in  1  mode select: 0 = MixColumns, 1 = InvMixColumns. Sampled at accept.
- `i_data`  in  128  input state. Column c occupies `[127-32c -: 32]`; row 0 is the MSB byte of each column.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts result.
- `o_data`  out  128  result state, same byte layout as `i_data`.
- `o_busy`  out  1  high whenever the state is BUSY or DONE.

## Operation
- Accept: on a clock edge where `i_valid && o_ready`. At accept the engine latches `i_data` into the 128-bit state register and latches `i_inv`, clears the column counter and moves to BUSY.
- Per-column arithmetic, GF(2^8) with reduction polynomial 0x11B (xtime = shift left by 1, then XOR 8'h1b if the pre-shift MSB was set):
  - Forward: out_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3).
  - Inverse: out_r = e·a_r ^ b·a_(r+1) ^ d·a_(r+2) ^ 9·a_(r+3).
  - Row indices are taken mod 4.
- States:
  - IDLE: `o_ready=1`, `o_valid=0`.
  - BUSY: on each edge, transform columns `cnt*COLS_PER_CYC` through `cnt*COLS_PER_CYC+COLS_PER_CYC-1` in place, then `cnt += 1`. When `cnt` reaches `4/COLS_PER_CYC-1`, that edge transforms the final columns and moves the state to DONE. `o_ready=0` throughout BUSY.
  - DONE: `o_valid=1`. `o_data` shows the state register and is held stable until `i_ready` is sampled high.
    - `i_ready && !i_valid`: go to IDLE.
    - `i_ready && i_valid`: accept the new input on the same edge and go to BUSY (back-to-back).
    - `i_ready` low: stay in DONE.
- `o_ready` = (state==IDLE) || (state==DONE && i_ready). It is combinational on `i_ready`.
- Columns not yet processed keep their input values. `o_data` is only meaningful while `o_valid` is high.
- `i_inv` and `i_data` are ignored outside accept edges. Changing them mid-transaction has no effect.

## Timing
- Reset value of every output, applied asynchronously on `i_rst_n` low:
  - `o_valid=0`, `o_busy=0`, `o_data=128'h0`, `o_ready=1`.
  - Internally: state IDLE, counter 0, mode 0.
- Reset mid-transaction (BUSY or DONE) discards the state. After release, the engine is IDLE with no output pending.
- Latency is N = 4/COLS_PER_CYC edges from the accept edge to the first cycle `o_valid` is high: 4, 2 or 1 for COLS_PER_CYC = 1, 2 or 4.
- Throughput with `i_ready` held high is one state every N+1 cycles: N BUSY cycles plus one DONE cycle, which overlaps the next accept.
- Critical path at COLS_PER_CYC=4 is the full inverse matrix on 16 bytes. COLS_PER_CYC=1 needs only 4 byte multiplier sets, muxed by counter.

## Configuration
- `AES_MC_BYPASS_EN` defined:
  - Adds port `i_bypass`, in, 1.
  - `i_bypass` is latched at accept alongside `i_inv`.
  - When the latched value is 1, BUSY cycles leave columns unchanged. `o_data` then equals the accepted `i_data` with identical latency and handshake behaviour. This serves the final AES round.
- `AES_MC_BYPASS_EN` undefined: the port is absent and every transaction is transformed.

## Test plan
- Reset, then COLS_PER_CYC=4, forward mode, `i_data=128'hdb135345_f20a225c_01010101_c6c6c6c6` → `o_data=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6` with `o_valid` high 1 cycle after accept.
- COLS_PER_CYC=1, inverse mode, `i_data=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6` → `o_data=128'hdb135345_f20a225c_01010101_c6c6c6c6` after 4 cycles, with `o_ready=0` during BUSY.
- COLS_PER_CYC=2, forward mode, `128'hd4d4d4d5_2d26314c_00000000_ffffffff` → `128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff`. Hold `i_ready=0` for 5 cycles and check `o_data`/`o_valid` stay stable. Then, with `i_ready=1` and `i_valid=1`, check the back-to-back accept occurs on the same edge.
- Assert `i_rst_n` low during BUSY (COLS_PER_CYC=1, second column) → `o_valid=0`, `o_data=0` and `o_ready=1` immediately. No stale result appears after release.
- With `AES_MC_BYPASS_EN` defined, `i_bypass=1`, `i_data=128'h00112233_44556677_8899aabb_ccddeeff` → identical `o_data` after N cycles. The same input with `i_bypass=0` → forward MixColumns result.
